// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: state encoding, default
// parameters and the width helper used to size index and counter fields.
package fifo_arb_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BURST = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   localparam int NUM_REQ_DEF   = 4;
   localparam int DATA_SIZE_DEF = 8;
   localparam int BURST_LEN_DEF = 4;

   // Bits needed to hold values 0..v-1 (0 for v <= 1).
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first active requester strictly after last_owner,
// wrapping from NUM_REQ-1 back to 0.
module rr_pick import fifo_arb_pkg::*; #(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int IDX_W   = clog2(NUM_REQ_DEF)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_owner,
   output logic               valid,
   output logic [IDX_W-1:0]   index
);

   logic [IDX_W-1:0] cand;
   logic             found;

   assign valid = |req;

   always_comb begin
      index = '0;
      found = 1'b0;
      cand  = '0;
      // k = NUM_REQ revisits last_owner itself, so a lone requester is still picked.
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((int'(last_owner) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            index = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-limited round-robin arbiter that merges NUM_REQ producers into one
// downstream FIFO write port, pausing in HOLD while the FIFO is full.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
   parameter int NUM_REQ   = NUM_REQ_DEF,
   parameter int DATA_SIZE = DATA_SIZE_DEF,
   parameter int BURST_LEN = BURST_LEN_DEF
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
   input  logic                           fifo_full,
   output logic                           push,
   output logic [DATA_SIZE-1:0]           push_data,
   output logic [NUM_REQ-1:0]             gnt,
   output logic [clog2(NUM_REQ)-1:0]      owner,
   output logic                           busy
);

   localparam int IDX_W  = clog2(NUM_REQ);
   localparam int BEAT_W = clog2(BURST_LEN) + 1;

   logic [1:0]        state;
   logic [BEAT_W-1:0] beat;
   logic [IDX_W-1:0]  last_owner;
   logic              pick_valid;
   logic [IDX_W-1:0]  pick_idx;
   logic              last_beat;
   logic              release_gnt;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req        (req),
      .last_owner (last_owner),
      .valid      (pick_valid),
      .index      (pick_idx)
   );

   assign busy      = (state != ST_IDLE);
   assign push      = (state == ST_BURST) && req[owner] && !fifo_full;
   assign push_data = busy ? req_data[int'(owner)*DATA_SIZE +: DATA_SIZE] : '0;
   assign last_beat = push && (beat == BEAT_W'(BURST_LEN - 1));

   // Grant ends on the final beat or as soon as the owner stops requesting.
   assign release_gnt = ((state == ST_BURST) && (last_beat || !req[owner])) ||
                        ((state == ST_HOLD)  && !req[owner]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         gnt        <= '0;
         owner      <= '0;
         beat       <= '0;
         last_owner <= IDX_W'(NUM_REQ - 1);
      end else if (release_gnt) begin
         state      <= ST_IDLE;
         gnt        <= '0;
         owner      <= '0;
         last_owner <= owner;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  state <= ST_BURST;
                  gnt   <= NUM_REQ'(1) << pick_idx;
                  owner <= pick_idx;
                  beat  <= '0;
               end
            end
            ST_BURST: begin
               if (push) beat <= beat + BEAT_W'(1);
               else if (fifo_full) state <= ST_HOLD;
            end
            ST_HOLD: begin
               // Return to BURST first; the push follows a cycle later.
               if (!fifo_full) state <= ST_BURST;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a per-cycle vector table plus
// producer/FIFO model driven sequences for the multi-cycle corner cases.
module tb_fifo_wr_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic        fifo_full;
   logic        push;
   logic [7:0]  push_data;
   logic [3:0]  gnt;
   logic [1:0]  owner;
   logic        busy;

   fifo_wr_arbiter #(.NUM_REQ(4), .DATA_SIZE(8), .BURST_LEN(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_data  (req_data),
      .fifo_full (fifo_full),
      .push      (push),
      .push_data (push_data),
      .gnt       (gnt),
      .owner     (owner),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int checks;
   int failures;

   // producer / FIFO model
   int         rem [4];
   int         seq [4];
   int         cnt;
   int         depth;
   bit         force_full;
   int         cyc;
   int         overflow;
   logic [3:0] prev_gnt;
   int         push_cyc [$];
   int         push_dat [$];
   int         push_own [$];
   int         gnt_log [$];
   int         burst_pushes [$];

   typedef struct {
      logic [3:0] req;
      logic       full;
      logic [3:0] gnt;
      logic       push;
      logic [1:0] owner;
      logic       busy;
      logic [7:0] pdata;
   } vec_t;

   vec_t tv [14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_logs();
      prev_gnt = '0;
      overflow = 0;
      cyc      = 0;
      push_cyc.delete();
      push_dat.delete();
      push_own.delete();
      gnt_log.delete();
      burst_pushes.delete();
   endtask

   task automatic clear_model();
      for (int i = 0; i < 4; i++) begin
         rem[i] = 0;
         seq[i] = 0;
      end
      cnt        = 0;
      depth      = 1000;
      force_full = 1'b0;
      clear_logs();
   endtask

   task automatic apply_inputs();
      for (int i = 0; i < 4; i++) begin
         req[i]          = (rem[i] > 0);
         req_data[i*8+:8] = 8'(i*16 + seq[i]);
      end
      fifo_full = force_full || (cnt >= depth);
   endtask

   // One clock: sample at negedge, update the model just after the posedge.
   task automatic step();
      logic       p;
      logic [3:0] g;
      @(negedge clk);
      if (gnt != 4'b0 && gnt != prev_gnt) begin
         gnt_log.push_back(int'(gnt));
         burst_pushes.push_back(0);
      end
      prev_gnt = gnt;
      p = push;
      g = gnt;
      if (push) begin
         if (fifo_full) overflow++;
         push_cyc.push_back(cyc);
         push_dat.push_back(int'(push_data));
         push_own.push_back(int'(owner));
         if (burst_pushes.size() > 0) burst_pushes[burst_pushes.size()-1]++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (p) begin
         for (int i = 0; i < 4; i++) begin
            if (g[i]) begin
               rem[i]--;
               seq[i]++;
            end
         end
         cnt++;
      end
      apply_inputs();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_model();
      apply_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 64'({gnt, push, owner, busy, push_data}), 64'(0));
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      clk       = 1'b0;
      rst       = 1'b0;
      req       = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      checks    = 0;
      failures  = 0;

      //            req     full  gnt     push  own   busy  pdata
      tv[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};
      tv[1]  = '{4'b0101, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};
      tv[2]  = '{4'b0101, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 8'hA0};
      tv[3]  = '{4'b0100, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b1, 8'hA0};
      tv[4]  = '{4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};
      tv[5]  = '{4'b0100, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b1, 8'hA2};
      tv[6]  = '{4'b0100, 1'b0, 4'b0100, 1'b0, 2'd2, 1'b1, 8'hA2};
      tv[7]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 8'hA2};
      tv[8]  = '{4'b0011, 1'b0, 4'b0100, 1'b0, 2'd2, 1'b1, 8'hA2};
      tv[9]  = '{4'b0011, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};
      tv[10] = '{4'b0011, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 8'hA0};
      tv[11] = '{4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1, 8'hA0};
      tv[12] = '{4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1, 8'hA0};
      tv[13] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};

      // Vector table: owner drop, HOLD/bubble, non-owner request, HOLD exit on req drop
      do_reset();
      req_data = 32'hA3A2A1A0;
      for (int v = 0; v < 14; v++) begin
         req       = tv[v].req;
         fifo_full = tv[v].full;
         @(negedge clk);
         chk($sformatf("vec%0d", v), 64'({gnt, push, owner, busy, push_data}),
             64'({tv[v].gnt, tv[v].push, tv[v].owner, tv[v].busy, tv[v].pdata}));
         @(posedge clk);
         #1;
      end

      // Single producer, 6 words: 4 pushes, one idle cycle, regrant, 2 pushes
      do_reset();
      rem[0] = 6;
      apply_inputs();
      repeat (14) step();
      chk("single_push_count", 64'(push_cyc.size()), 64'(6));
      if (push_cyc.size() == 6) begin
         chk("single_burst_span", 64'(push_cyc[3] - push_cyc[0]), 64'(3));
         chk("single_idle_gap", 64'(push_cyc[4] - push_cyc[3]), 64'(2));
         chk("single_tail", 64'(push_cyc[5] - push_cyc[4]), 64'(1));
         for (int k = 0; k < 6; k++) chk($sformatf("single_data%0d", k), 64'(push_dat[k]), 64'(k));
      end
      chk("single_grants", 64'(gnt_log.size()), 64'(2));

      // All four requesting: grants rotate 0,1,2,3,0 with 4 pushes each
      do_reset();
      for (int i = 0; i < 4; i++) rem[i] = 100;
      apply_inputs();
      repeat (30) step();
      chk("rr_grant_count", 64'(gnt_log.size() >= 5), 64'(1));
      if (gnt_log.size() >= 5) begin
         chk("rr_gnt0", 64'(gnt_log[0]), 64'(4'b0001));
         chk("rr_gnt1", 64'(gnt_log[1]), 64'(4'b0010));
         chk("rr_gnt2", 64'(gnt_log[2]), 64'(4'b0100));
         chk("rr_gnt3", 64'(gnt_log[3]), 64'(4'b1000));
         chk("rr_gnt4", 64'(gnt_log[4]), 64'(4'b0001));
         for (int b = 0; b < 4; b++) chk($sformatf("rr_beats%0d", b), 64'(burst_pushes[b]), 64'(4));
      end
      if (push_dat.size() >= 13) begin
         chk("rr_data_p1", 64'(push_dat[4]), 64'(8'h10));
         chk("rr_data_p3", 64'(push_dat[12]), 64'(8'h30));
      end else chk("rr_push_count", 64'(push_dat.size()), 64'(13));

      // fifo_full for 3 cycles after beat 2: HOLD, bubble, then beats 3-4
      do_reset();
      rem[0] = 4;
      apply_inputs();
      for (int t = 0; t < 10 && push_cyc.size() < 2; t++) step();
      force_full = 1'b1;
      apply_inputs();
      repeat (3) step();
      force_full = 1'b0;
      apply_inputs();
      repeat (8) step();
      chk("hold_push_count", 64'(push_cyc.size()), 64'(4));
      if (push_cyc.size() == 4) begin
         chk("hold_resume_gap", 64'(push_cyc[2] - push_cyc[1]), 64'(5));
         chk("hold_last_beat", 64'(push_cyc[3] - push_cyc[2]), 64'(1));
         chk("hold_data3", 64'(push_dat[3]), 64'(3));
      end
      chk("hold_no_push_full", 64'(overflow), 64'(0));
      chk("hold_single_grant", 64'(gnt_log.size()), 64'(1));

      // Reset asserted mid-burst at beat 2, then req=1010 grants producer 1
      do_reset();
      rem[0] = 10;
      apply_inputs();
      for (int t = 0; t < 10 && push_cyc.size() < 2; t++) step();
      chk("rst_mid_busy_before", 64'({busy, gnt}), 64'({1'b1, 4'b0001}));
      rst = 1'b0;
      #1;
      chk("rst_mid_async", 64'({gnt, push, owner, busy, push_data}), 64'(0));
      rem[0] = 0;
      rem[1] = 5;
      rem[3] = 5;
      apply_inputs();
      clear_logs();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      repeat (6) step();
      chk("rst_first_gnt", 64'(gnt_log.size() > 0 ? gnt_log[0] : 0), 64'(4'b0010));
      chk("rst_first_owner", 64'(push_own.size() > 0 ? push_own[0] : 9), 64'(1));

      // 8-deep FIFO, no pops, 3 producers: exactly 8 pushes then HOLD on producer 2
      do_reset();
      depth = 8;
      for (int i = 0; i < 3; i++) rem[i] = 10;
      apply_inputs();
      repeat (40) step();
      chk("fill_push_count", 64'(push_cyc.size()), 64'(8));
      chk("fill_overflow", 64'(overflow), 64'(0));
      chk("fill_hold_state", 64'({busy, gnt, push}), 64'({1'b1, 4'b0100, 1'b0}));
      if (push_dat.size() >= 5) chk("fill_data_p1", 64'(push_dat[4]), 64'(8'h10));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
